cuckoo_controller: RTL

Sequential, parametrised successor of the combinational hash-table controller. Accepts one read/write/delete request at a time over a valid/ready handshake and sequences the synchronous bucket memories of NUMBER_OF_TABLES tables. On a full-table write it resolves the collision with a bounded cuckoo eviction chain before falling back to the overflow CAM, and returns a registered response with a status code. Sits between the host request interface and the per-table memories, hash units and CAM.

---
 rtl/cuckoo_controller.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cuckoo_controller.sv
// Sequential cuckoo hash-table controller: serves one read/write/delete at a time,
// resolves full-bucket writes with a bounded eviction chain, then spills into the CAM.
module cuckoo_controller #(
  parameter int KEY_WIDTH           = 2,
  parameter int DATA_WIDTH          = 32,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int BUCKET_SIZE         = 1,
  parameter int HASH_TABLE_MAX_SIZE = 2,
  parameter int CAM_SIZE            = 64,
  parameter int MAX_KICKS           = 4
) (
  input  logic                                                            clk,
  input  logic                                                            reset,
  input  logic                                                            clk_en,
  input  logic                                                            req_valid_i,
  output logic                                                            req_ready_o,
  input  logic [1:0]                                                      op_i,
  input  logic [KEY_WIDTH-1:0]                                            key_i,
  input  logic [DATA_WIDTH-1:0]                                           data_i,
  output logic [KEY_WIDTH-1:0]                                            hash_key_o,
  input  logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE-1:0]                 hash_adr_i,
  output logic                                                            mem_rd_en_o,
  output logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE-1:0]                 mem_adr_o,
  input  logic [NUMBER_OF_TABLES*(KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE-1:0]  read_out_content_i,
  input  logic [NUMBER_OF_TABLES*BUCKET_SIZE-1:0]                         valid_flags_i,
  output logic [NUMBER_OF_TABLES-1:0]                                     write_en_o,
  output logic [NUMBER_OF_TABLES*BUCKET_SIZE-1:0]                         write_valid_flag_o,
  output logic [NUMBER_OF_TABLES*(KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE-1:0]  write_content_o,
  output logic [KEY_WIDTH-1:0]                                            CAM_key_o,
  output logic [DATA_WIDTH-1:0]                                           CAM_data_o,
  input  logic [DATA_WIDTH-1:0]                                           CAM_data_i,
  input  logic                                                            CAM_valid_i,
  output logic                                                            CAM_write_en_o,
  output logic                                                            CAM_delete_o,
  output logic [$clog2(CAM_SIZE+1)-1:0]                                   cam_count_o,
  output logic                                                            resp_valid_o,
  output logic [DATA_WIDTH-1:0]                                           read_data_o,
  output logic [2:0]                                                      status_o
);
  localparam int T  = NUMBER_OF_TABLES;
  localparam int B  = BUCKET_SIZE;
  localparam int K  = KEY_WIDTH;
  localparam int D  = DATA_WIDTH;
  localparam int E  = K + D;
  localparam int BW = E * B;
  localparam int A  = HASH_TABLE_MAX_SIZE;
  localparam int CW = $clog2(CAM_SIZE+1);
  localparam int KW = (MAX_KICKS > 0) ? $clog2(MAX_KICKS+1) : 1;
  localparam int RW = (T > 1) ? $clog2(T) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOOKUP  = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;

  localparam logic [2:0] ST_OK          = 3'd0;
  localparam logic [2:0] ST_NOT_FOUND   = 3'd1;
  localparam logic [2:0] ST_KEY_PRESENT = 3'd2;
  localparam logic [2:0] ST_NO_SPACE    = 3'd3;
  localparam logic [2:0] ST_NO_DEL      = 3'd4;

  logic [1:0]     state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [K-1:0]   key_q, key_d;
  logic [D-1:0]   data_q, data_d;
  logic [KW-1:0]  kick_q, kick_d;
  logic [RW-1:0]  rr_q, rr_d;
  logic [T*A-1:0] adr_q, adr_d;
  logic [CW-1:0]  cam_count_q, cam_count_d;
  logic [D-1:0]   read_data_q, read_data_d;
  logic [2:0]     status_q, status_d;

  logic         tbl_hit, free_found;
  int           hit_t, hit_b, free_t, free_b;
  logic [D-1:0] hit_data;

  logic wr_en, wr_clear, cam_we, cam_del, cam_full;
  int   wr_t, wr_b, vic_b;

  // Scan every bucket entry once for a key match and for the first free slot.
  always_comb begin
    tbl_hit    = 1'b0;
    hit_t      = 0;
    hit_b      = 0;
    hit_data   = '0;
    free_found = 1'b0;
    free_t     = 0;
    free_b     = 0;
    for (int t = 0; t < T; t++) begin
      for (int b = 0; b < B; b++) begin
        if (valid_flags_i[t*B+b] && read_out_content_i[t*BW+b*E+D +: K] == key_q) begin
          tbl_hit  = 1'b1;
          hit_t    = t;
          hit_b    = b;
          hit_data = read_out_content_i[t*BW+b*E +: D];
        end
        if (!valid_flags_i[t*B+b] && !free_found) begin
          free_found = 1'b1;
          free_t     = t;
          free_b     = b;
        end
      end
    end
  end

  assign cam_full = (cam_count_q == CW'(CAM_SIZE));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    data_d      = data_q;
    kick_d      = kick_q;
    rr_d        = rr_q;
    adr_d       = adr_q;
    cam_count_d = cam_count_q;
    read_data_d = read_data_q;
    status_d    = status_q;
    wr_en       = 1'b0;
    wr_clear    = 1'b0;
    wr_t        = 0;
    wr_b        = 0;
    cam_we      = 1'b0;
    cam_del     = 1'b0;
    vic_b       = int'(kick_q) % B;
    case (state_q)
      IDLE: begin
        if (req_valid_i && op_i != OP_NONE) begin
          op_d    = op_i;
          key_d   = key_i;
          data_d  = data_i;
          kick_d  = '0;
          rr_d    = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        adr_d   = hash_adr_i;
        state_d = COMPARE;
      end
      COMPARE: begin
        state_d     = RESP;
        read_data_d = '0;
        case (op_q)
          OP_READ: begin
            if (tbl_hit) begin
              read_data_d = hit_data;
              status_d    = ST_OK;
            end else if (CAM_valid_i) begin
              read_data_d = CAM_data_i;
              status_d    = ST_OK;
            end else begin
              status_d = ST_NOT_FOUND;
            end
          end
          OP_DELETE: begin
            if (tbl_hit) begin
              wr_en    = 1'b1;
              wr_clear = 1'b1;
              wr_t     = hit_t;
              wr_b     = hit_b;
              status_d = ST_OK;
            end else if (CAM_valid_i) begin
              cam_del  = 1'b1;
              if (cam_count_q != '0) cam_count_d = cam_count_q - CW'(1);
              status_d = ST_OK;
            end else begin
              status_d = ST_NO_DEL;
            end
          end
          OP_WRITE: begin
            // The displaced victim carried by a chain is unique, so hits only matter on the first pass.
            if (kick_q == '0 && (tbl_hit || CAM_valid_i)) begin
              status_d = ST_KEY_PRESENT;
            end else if (free_found) begin
              wr_en    = 1'b1;
              wr_t     = free_t;
              wr_b     = free_b;
              status_d = ST_OK;
            end else if (!cam_full && kick_q < KW'(MAX_KICKS)) begin
              wr_en           = 1'b1;
              wr_t            = int'(rr_q);
              wr_b            = vic_b;
              {key_d, data_d} = read_out_content_i[int'(rr_q)*BW + vic_b*E +: E];
              kick_d          = kick_q + KW'(1);
              rr_d            = (rr_q == RW'(T-1)) ? '0 : rr_q + RW'(1);
              state_d         = LOOKUP;
            end else if (!cam_full) begin
              cam_we      = 1'b1;
              cam_count_d = cam_count_q + CW'(1);
              status_d    = ST_OK;
            end else begin
              status_d = ST_NO_SPACE;
            end
          end
          default: status_d = ST_OK;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // A table write rewrites the whole bucket: untouched entries are passed through as read.
  always_comb begin
    write_en_o         = '0;
    write_valid_flag_o = '0;
    write_content_o    = '0;
    for (int t = 0; t < T; t++) begin
      if (wr_en && t == wr_t) begin
        write_en_o[t]               = clk_en;
        write_valid_flag_o[t*B +: B] = valid_flags_i[t*B +: B];
        write_content_o[t*BW +: BW]  = read_out_content_i[t*BW +: BW];
        for (int b = 0; b < B; b++) begin
          if (b == wr_b) begin
            write_valid_flag_o[t*B+b] = !wr_clear;
            if (!wr_clear) write_content_o[t*BW+b*E +: E] = {key_q, data_q};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      key_q       <= '0;
      data_q      <= '0;
      kick_q      <= '0;
      rr_q        <= '0;
      adr_q       <= '0;
      cam_count_q <= '0;
      read_data_q <= '0;
      status_q    <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      data_q      <= data_d;
      kick_q      <= kick_d;
      rr_q        <= rr_d;
      adr_q       <= adr_d;
      cam_count_q <= cam_count_d;
      read_data_q <= read_data_d;
      status_q    <= status_d;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign hash_key_o     = key_q;
  assign CAM_key_o      = key_q;
  assign CAM_data_o     = data_q;
  assign mem_rd_en_o    = (state_q == LOOKUP) && clk_en;
  assign mem_adr_o      = (state_q == LOOKUP) ? hash_adr_i : adr_q;
  assign CAM_write_en_o = cam_we && clk_en;
  assign CAM_delete_o   = cam_del && clk_en;
  assign cam_count_o    = cam_count_q;
  assign resp_valid_o   = (state_q == RESP) && clk_en;
  assign read_data_o    = read_data_q;
  assign status_o       = status_q;

endmodule
